// File: rtl/operation16.sv
// -----------------------------------------------------------------------------
// operation16 -- registered 16-bit ripple-carry adder with load strobe.
//
// Computes {r1, s} = e1 + e2 + r0 through a chain of one-bit full adders and
// captures the result on a rising clock edge where en is high. When en is low
// the sum and carry keep their last value and valid drops for that cycle.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset (clears s, r1, valid)
//   en     in   1      load strobe, capture operands/carry-in on this edge
//   e1     in   WIDTH  first unsigned operand
//   e2     in   WIDTH  second unsigned operand
//   r0     in   1      carry-in
//   s      out  WIDTH  registered sum, low WIDTH bits
//   r1     out  1      registered carry-out (bit WIDTH of the sum)
//   valid  out  1      high for the cycle after an en-qualified capture
// -----------------------------------------------------------------------------
module operation16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] e1,
  input  logic [WIDTH-1:0] e2,
  input  logic             r0,
  output logic [WIDTH-1:0] s,
  output logic             r1,
  output logic             valid
);

  // One-bit full adder; returns {cout, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    logic p;
    p = a ^ b;
    return {(a & b) | (cin & p), p ^ cin};
  endfunction

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;

  logic [WIDTH-1:0] s_q, s_d;
  logic             r1_q, r1_d;
  logic             valid_q, valid_d;

  assign carry_s[0] = r0;

  // Ripple chain: each stage takes the carry-out of the stage below it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign {carry_s[i+1], sum_s[i]} = full_add(e1[i], e2[i], carry_s[i]);
  end

  // Next-state selection: capture on en, otherwise hold result and drop valid.
  always_comb begin
    s_d     = s_q;
    r1_d    = r1_q;
    valid_d = 1'b0;
    if (en) begin
      s_d     = sum_s;
      r1_d    = carry_s[WIDTH];
      valid_d = 1'b1;
    end else begin
      s_d     = s_q;
      r1_d    = r1_q;
      valid_d = 1'b0;
    end
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= {WIDTH{1'b0}};
      r1_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      r1_q    <= r1_d;
      valid_q <= valid_d;
    end
  end

  assign s     = s_q;
  assign r1    = r1_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_operation16.sv
// -----------------------------------------------------------------------------
// tb_operation16 -- self-checking bench for operation16.
// Directed vectors with hand-computed results applied from a table, followed
// by reset, input-stability and random-sum sequences.
// -----------------------------------------------------------------------------
module tb_operation16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] e1;
  logic [15:0] e2;
  logic        r0;
  logic [15:0] s;
  logic        r1;
  logic        valid;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        en;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        r0;
    logic [15:0] exp_s;
    logic        exp_r1;
    logic        exp_v;
  } vec_t;

  vec_t vecs[$];

  operation16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .e1    (e1),
    .e2    (e2),
    .r0    (r0),
    .s     (s),
    .r1    (r1),
    .valid (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] xs, input logic xr1, input logic xv);
    n_cmp++;
    if (s !== xs || r1 !== xr1 || valid !== xv) begin
      n_fail++;
      $display("FAIL %s: got s=%h r1=%b valid=%b, expected s=%h r1=%b valid=%b",
               name, s, r1, valid, xs, xr1, xv);
    end
  endtask

  // Drive inputs (called at a falling edge), clock once, sample at next falling edge.
  task automatic step(input logic ven, input logic [15:0] a, input logic [15:0] b, input logic c);
    en = ven; e1 = a; e2 = b; r0 = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [16:0] model;
    logic [15:0] ra, rb;
    logic        rc;

    n_cmp  = 0;
    n_fail = 0;

    //            en    e1        e2        r0    s         r1    valid
    vecs.push_back('{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 16'h6081, 16'h4106, 1'b1, 16'hA188, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 16'h8213, 16'h1080, 1'b1, 16'h9294, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 16'h1111, 16'h2222, 1'b1, 16'h9294, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 16'h0001, 16'h7FFF, 1'b0, 16'h8000, 1'b0, 1'b1});

    // Reset held with en high: outputs stay clear.
    rst_n = 1'b0; en = 1'b1; e1 = 16'h1234; e2 = 16'h4321; r0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_en", 16'h0000, 1'b0, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].e1, vecs[i].e2, vecs[i].r0);
      check($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_r1, vecs[i].exp_v);
    end

    // Mid-operation reset: pending capture with e1=0x8908 is discarded.
    en = 1'b1; e1 = 16'h8908; e2 = 16'h0101; r0 = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_clear", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("reset_discard", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 16'h8908, 16'h0101, 1'b0);
    check("release_no_result", 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h8908, 16'h0000, 1'b1);
    check("first_after_release", 16'h8909, 1'b0, 1'b1);

    // Inputs wiggling between edges must not disturb the registered result.
    en = 1'b1; e1 = 16'hFFFF; e2 = 16'h0001; r0 = 1'b0;
    #1 check("stable_between_edges", 16'h8909, 1'b0, 1'b1);
    e1 = 16'h0F0F; #1 e1 = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    check("wrap_carry", 16'h0000, 1'b1, 1'b1);

    // Random back-to-back captures against a 17-bit reference sum.
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      model = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      step(1'b1, ra, rb, rc);
      check("random", model[15:0], model[16], 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/operation16.md
OPERATION16 -- requirements
Module: operation16

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 en  input  1  load strobe; high = capture operands and carry-in this edge.
REQ-005 e1  input  16  first operand, unsigned.
REQ-006 e2  input  16  second operand, unsigned.
REQ-007 r0  input  1  carry-in.
REQ-008 s  output  16  registered sum, low 16 bits.
REQ-009 r1  output  1  registered carry-out, bit 16 of the sum.
REQ-010 valid  output  1  high for the cycle in which s/r1 hold a result computed from an en-qualified capture.

Function
REQ-011 Arithmetic: {r1,s} SHALL equal e1 + e2 + r0, computed at 17-bit width, with no truncation before bit 16.
REQ-012 The combinational sum SHALL be a ripple-carry chain of 16 one-bit full-adder stages.
REQ-013 Stage 0 carry-in SHALL be r0, each stage i carry-in SHALL be stage i-1 carry-out, and r1 SHALL be the stage 15 carry-out.
REQ-014 Full-adder stage: sum = a XOR b XOR cin; cout = (a AND b) OR (cin AND (a XOR b)).
REQ-015 Latency: inputs sampled on edge N with en=1 SHALL appear on s/r1 after edge N, with valid=1 until edge N+1.
REQ-016 en=0 on an edge: s and r1 SHALL hold their previous values, and valid SHALL go 0.
REQ-017 Back-to-back: en=1 on consecutive edges SHALL give one result per cycle, with valid held at 1.
REQ-018 Wrap-around: a sum greater than 0xFFFF SHALL set r1=1, with s = sum modulo 2^16.
REQ-019 Overflow is treated as unsigned; no signed-overflow flag is produced.
REQ-020 Inputs changing between edges SHALL NOT affect s, r1 or valid.
REQ-021 X/Z on an operand SHALL NOT be masked; the output is undefined for that capture only.

Reset
REQ-022 While rst_n=0, s, r1 and valid SHALL be 0, regardless of clk and en.
REQ-023 Reset asserted mid-operation SHALL clear the outputs immediately (asynchronously) and discard any pending capture.
REQ-024 Deassertion SHALL take effect at the next rising edge; the first edge with rst_n=1 and en=1 captures normally.
REQ-025 After reset there are no internal state bits other than s, r1 and valid.

Verification
REQ-026 Reset: rst_n=0, then en=1 with e1=e2=0, r0=0 -> s=0x0000, r1=0, valid=1 one edge later.
REQ-027 e1=0x6081, e2=0x4106, r0=1, en=1 -> s=0xA188, r1=0 after one edge.
REQ-028 e1=0x8213, e2=0x1080, r0=1 -> s=0x9294, r1=0; then en=0 -> s and r1 held, valid=0.
REQ-029 Carry propagation:
- e1=0xFFFF, e2=0x0000, r0=1 -> s=0x0000, r1=1.
- e1=0xFFFF, e2=0xFFFF, r0=1 -> s=0xFFFF, r1=1.
REQ-030 Mid-operation reset: en=1 with e1=0x8908 on the cycle rst_n drops -> s=0, r1=0, valid=0 at once, with no result after release until a new en=1.
REQ-031 Randomised: 1000 en=1 vectors -> {r1,s} equals the 17-bit sum of the previous cycle's inputs.
